// File: rtl/chip8_vga_scaler.sv
// CHIP-8 framebuffer to 640x480@60 VGA scaler: 512x256 window centred on the screen, 2-cycle video pipeline.
// Hires (128x64) addressing is built only when CHIP8_VGA_HIRES_EN is defined; otherwise the block is lores (64x32) only.
module chip8_vga_scaler #(
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h0000FF,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        hires,
  output logic [12:0] fb_addr,
  input  logic        fb_rdata,
  output logic        frame_start,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  localparam logic [10:0] H_LAST     = 11'd1599;
  localparam logic [10:0] H_VIS      = 11'd1280;
  localparam logic [10:0] HS_START   = 11'd1312;
  localparam logic [10:0] HS_END     = 11'd1503;
  localparam logic [9:0]  V_LAST     = 10'd524;
  localparam logic [9:0]  V_VIS      = 10'd480;
  localparam logic [9:0]  VS_START   = 10'd490;
  localparam logic [9:0]  VS_END     = 10'd491;
  localparam logic [9:0]  WIN_X0     = 10'd64;
  localparam logic [9:0]  WIN_X1     = 10'd575;
  localparam logic [9:0]  WIN_Y0     = 10'd112;
  localparam logic [9:0]  WIN_Y1     = 10'd367;

`ifdef CHIP8_VGA_HIRES_EN
  localparam logic [12:0] ADDR_MASK  = 13'h1FFF;
`else
  localparam logic [12:0] ADDR_MASK  = 13'h07FF;
  logic hires_unused_s;
  assign hires_unused_s = hires;
`endif

  // Window-relative offsets are formed in 13 bits so the edge pixels never wrap.
  function automatic logic [12:0] win_addr(input logic [9:0] x, input logic [9:0] y, input logic hi);
    logic [12:0] dx;
    logic [12:0] dy;
    dx = {3'b000, x} - 13'd64;
    dy = {3'b000, y} - 13'd112;
    if (hi) begin
      win_addr = ((dy >> 2) * 13'd128) + (dx >> 2);
    end else begin
      win_addr = ((dy >> 3) * 13'd64) + (dx >> 3);
    end
  endfunction

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        mode_q, mode_d;
  logic        frame_start_q, frame_start_d;
  logic [12:0] fb_addr_q, fb_addr_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d, inwin1_q, inwin1_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;
  logic [23:0] rgb_q, rgb_d;

  logic [9:0]  x_s;
  logic [9:0]  y_s;
  logic        frame_edge_s;
  logic        inwin_s;

  always_comb begin
    x_s          = hcount_q[10:1];
    y_s          = vcount_q;
    frame_edge_s = (hcount_q == 11'd0) && (vcount_q == V_VIS);
    inwin_s      = (x_s >= WIN_X0) && (x_s <= WIN_X1) && (y_s >= WIN_Y0) && (y_s <= WIN_Y1);

    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 11'd1;
      vcount_d = vcount_q;
    end

`ifdef CHIP8_VGA_HIRES_EN
    mode_d = frame_edge_s ? hires : mode_q;
`else
    mode_d = 1'b0;
`endif
    frame_start_d = frame_edge_s;

    // Stage 1: address plus raw timing, all describing the pixel under the counters.
    if (inwin_s) begin
      fb_addr_d = win_addr(x_s, y_s, mode_q) & ADDR_MASK;
    end else begin
      fb_addr_d = 13'd0;
    end
    hs1_d    = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
    vs1_d    = !((vcount_q >= VS_START) && (vcount_q <= VS_END));
    blank1_d = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    inwin1_d = inwin_s;

    // Stage 2: fb_rdata now answers the stage-1 address.
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    blank2_d = blank1_q;
    if (!blank1_q) begin
      rgb_d = 24'h000000;
    end else if (inwin1_q) begin
      if (fb_rdata) begin
        rgb_d = FG_RGB;
      end else begin
        rgb_d = BG_RGB;
      end
    end else begin
      rgb_d = BORDER_RGB;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      mode_q        <= 1'b0;
      frame_start_q <= 1'b0;
      fb_addr_q     <= 13'd0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      blank1_q      <= 1'b0;
      inwin1_q      <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank2_q      <= 1'b0;
      rgb_q         <= 24'h000000;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
      fb_addr_q     <= fb_addr_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      blank1_q      <= blank1_d;
      inwin1_q      <= inwin1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      blank2_q      <= blank2_d;
      rgb_q         <= rgb_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_n = blank2_q;
  assign VGA_CLK     = hcount_q[0];
  assign VGA_SYNC_n  = 1'b1;

endmodule

// File: tb/tb_chip8_vga_scaler.sv
// Scoreboard bench for chip8_vga_scaler: a frame-arithmetic reference model queues expected outputs, a monitor pops and compares.
module tb_chip8_vga_scaler;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h0000FF;
  localparam logic [23:0] BD = 24'h000000;
  localparam int unsigned FRAME = 1600 * 525;
  localparam int unsigned END_K = 768001 + FRAME + 2000;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        hires = 1'b0;
  logic [12:0] fb_addr;
  logic        fb_rdata;
  logic        frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  bit mem [8192];
  assign fb_rdata = mem[fb_addr];

  always #10 clk50 = ~clk50;

  chip8_vga_scaler dut (
    .clk50(clk50), .reset_n(reset_n), .hires(hires),
    .fb_addr(fb_addr), .fb_rdata(fb_rdata), .frame_start(frame_start),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  typedef struct { logic [12:0] addr; logic fs; } a_t;
  typedef struct { logic hs; logic vs; logic bn; logic [23:0] rgb; } v_t;
  a_t aq[$];
  v_t vq[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          run_m = 1'b0;
  int unsigned per_k = 0;
  bit          mode_m = 1'b0;
  int unsigned fs_k[$];
  int unsigned first_hs_k = 0;
  bit          hs_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, per_k, act, exp);
    end
  endtask

  // Reference model: the pixel at period k is derived purely from k and the frame rules.
  initial begin
    forever begin
      @(negedge clk50);
      #1;
      if (run_m) begin
        int unsigned h, v, x, y, addr;
        bit inwin, vis;
        logic [23:0] rgb;
        h = per_k % 1600;
        v = (per_k / 1600) % 525;
        x = h / 2;
        y = v;
        inwin = (x >= 64) && (x < 576) && (y >= 112) && (y < 368);
        if (!inwin) addr = 0;
        else if (mode_m) addr = ((y - 112) / 4) * 128 + (x - 64) / 4;
        else addr = ((y - 112) / 8) * 64 + (x - 64) / 8;
        vis = (h < 1280) && (v < 480);
        if (!vis) rgb = 24'h0;
        else if (inwin) rgb = mem[addr] ? FG : BG;
        else rgb = BD;
        aq.push_back('{addr: addr[12:0], fs: (h == 0 && v == 480)});
        vq.push_back('{hs: !(h >= 1312 && h <= 1503), vs: !(v == 490 || v == 491), bn: vis, rgb: rgb});
        if (h == 0 && v == 480) begin
`ifdef CHIP8_VGA_HIRES_EN
          mode_m = hires;
`else
          mode_m = 1'b0;
`endif
        end
      end
    end
  end

  // Monitor: fb_addr/frame_start lag the counters by one cycle, video by two.
  initial begin
    forever begin
      @(negedge clk50);
      #2;
      if (run_m) begin
        if (aq.size() == 2) begin
          a_t ea;
          ea = aq.pop_front();
          chk("fb_addr", {19'd0, fb_addr}, {19'd0, ea.addr});
          chk("frame_start", {31'd0, frame_start}, {31'd0, ea.fs});
        end
        if (vq.size() == 3) begin
          v_t ev;
          ev = vq.pop_front();
          chk("vga_hs", {31'd0, vga_hs}, {31'd0, ev.hs});
          chk("vga_vs", {31'd0, vga_vs}, {31'd0, ev.vs});
          chk("vga_blank_n", {31'd0, vga_blank_n}, {31'd0, ev.bn});
          chk("vga_rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, ev.rgb});
        end
        if (frame_start === 1'b1) fs_k.push_back(per_k);
        if (!hs_seen && vga_hs === 1'b0) begin
          hs_seen = 1'b1;
          first_hs_k = per_k;
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hs"}, {31'd0, vga_hs}, 32'd1);
    chk({tag, "_vs"}, {31'd0, vga_vs}, 32'd1);
    chk({tag, "_blank_n"}, {31'd0, vga_blank_n}, 32'd0);
    chk({tag, "_rgb"}, {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk({tag, "_fb_addr"}, {19'd0, fb_addr}, 32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_sync_n"}, {31'd0, vga_sync_n}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk50);
    #2;
    chk_reset_state("por");
    reset_n = 1'b1;
    repeat (300 + $urandom_range(0, 900)) @(negedge clk50);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_state("midline");
    repeat (2) @(negedge clk50);
    #2;
    chk_reset_state("held");
    @(negedge clk50);
    reset_n = 1'b1;
    per_k = 0;
    mode_m = 1'b0;
    run_m = 1'b1;
    while (per_k < END_K) begin
      @(negedge clk50);
      per_k++;
      begin
        int unsigned h, v, f;
        h = per_k % 1600;
        v = (per_k / 1600) % 525;
        f = per_k / FRAME;
        if (h == 0 && v == 200) hires = (f == 0);
        else if (h == 0 && v > 200 && v < 470) hires = 1'($urandom_range(0, 1));
        else if (h == 0 && v == 470) hires = (f == 0);
        else if (h == 7 && v == 480) hires = ~hires;
      end
    end
    run_m = 1'b0;
    chk("first_hs_low_k", first_hs_k, 32'd1314);
    chk("frame_start_count", fs_k.size(), 32'd2);
    chk("frame_start_first_k", (fs_k.size() > 0) ? fs_k[0] : 32'd0, 32'd768001);
    chk("frame_start_spacing", (fs_k.size() > 1) ? (fs_k[1] - fs_k[0]) : 32'd0, FRAME);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chip8_vga_scaler.md
CHIP8_VGA_SCALER -- requirements
Module: chip8_vga_scaler

Interface
REQ-001 SHALL have parameter FG_RGB, 24'hFFFFFF, colour of a lit framebuffer pixel.
REQ-002 SHALL have parameter BG_RGB, 24'h0000FF, colour of an unlit pixel inside the window.
REQ-003 SHALL have parameter BORDER_RGB, 24'h000000, colour of visible area outside the window.
REQ-004 SHALL have port clk50  input  1  50 MHz clock, the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port hires  input  1  1 = 128x64 mode, 0 = 64x32 mode.
REQ-007 SHALL have port fb_addr  output  13  framebuffer read address, registered.
REQ-008 SHALL have port fb_rdata  input  1  pixel bit, valid one clk50 after fb_addr.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse at start of vertical blank.
REQ-010 SHALL have ports VGA_R, VGA_G, VGA_B  output  8 each  pixel colour.
REQ-011 SHALL have ports VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  output  1 each  VGA control.

Function
REQ-012 SHALL count hcount 0..1599 every clk50 and vcount 0..524 on hcount wrap; pixel x = hcount[10:1], y = vcount.
REQ-013 SHALL drive raw HS low for hcount 1312..1503, raw VS low for vcount 490..491, raw blank_n high for hcount<1280 and vcount<480.
REQ-014 SHALL drive VGA_CLK = hcount[0] unregistered and VGA_SYNC_n constant 1.
REQ-015 SHALL define window x 64..575, y 112..367 (512x256) in both modes.
REQ-016 SHALL, in lores, set fb_addr = ((y-112)>>3)*64 + ((x-64)>>3), range 0..2047.
REQ-017 SHALL, in hires, set fb_addr = ((y-112)>>2)*128 + ((x-64)>>2), range 0..8191.
REQ-018 SHALL hold fb_addr at 0 outside the window.
REQ-019 SHALL form a 2-stage pipeline: stage 1 registers fb_addr plus delayed HS/VS/blank_n/in-window; stage 2 registers RGB from fb_rdata and re-registers HS/VS/blank_n.
REQ-020 SHALL make all of VGA_HS, VGA_VS, VGA_BLANK_n, VGA_R/G/B lag the counters by exactly 2 clk50 cycles, one pixel.
REQ-021 SHALL output RGB = FG_RGB when in-window and fb_rdata=1, BG_RGB when in-window and fb_rdata=0, BORDER_RGB when visible outside window, 0 when blanked.
REQ-022 SHALL sample hires into mode_q only at hcount=0, vcount=480; mode changes mid-frame take effect the next frame, never mid-frame.
REQ-023 SHALL pulse frame_start high for exactly one clk50 when hcount=0 and vcount=480, coincident with the mode_q update.
REQ-024 SHALL compute all address arithmetic in at least 13 bits without truncation at window edges.

Reset
REQ-025 SHALL, while reset_n=0, force hcount=0, vcount=0, mode_q=0, fb_addr=0, frame_start=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0, RGB=0 and clear all pipeline stages.
REQ-026 SHALL restart from hcount=0, vcount=0 on the first clk50 edge after reset_n rises; reset asserted mid-frame aborts the frame with no partial frame_start.

Configuration
REQ-027 SHALL compile hires support only when macro CHIP8_VGA_HIRES_EN is defined.
REQ-028 SHALL, without CHIP8_VGA_HIRES_EN, ignore the hires input, hold mode_q at 0 and tie fb_addr[12:11] to 0, leaving port widths unchanged.

Verification
REQ-029 SHALL cover reset: reset_n=0 mid-line -> VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0, RGB=0, fb_addr=0; release -> first HS low at hcount 1312, VGA_HS low 2 cycles later.
REQ-030 SHALL cover lores corners: x=64,y=112 -> fb_addr 0; x=575,y=367 -> fb_addr 2047; fb_rdata=1 -> RGB FFFFFF two cycles after counters.
REQ-031 SHALL cover hires with macro: x=575,y=367 -> fb_addr 8191; x=68,y=112 -> fb_addr 1.
REQ-032 SHALL cover mode change: hires toggled at vcount 200 -> addressing unchanged until vcount 480, new mode from frame_start.
REQ-033 SHALL cover border and blank: x=10,y=10 -> BORDER_RGB; hcount 1300 -> RGB 0, BLANK_n 0.
REQ-034 SHALL cover frame timing: 3 frames -> exactly 3 frame_start pulses 840000 cycles apart, VS low 2 lines per frame.
